// File: rtl/sa_buf_pkg.sv
// Shared constants and state type for the systolic-array input/output buffers.
package sa_buf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  // One extra bit so a full-depth burst length is representable.
  localparam int unsigned LEN_W  = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/input_buffer_mem.sv
// Operand register file: async-reset clear, one write port, one combinational read port.
module input_buffer_mem
  import sa_buf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, written one word per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port is purely combinational; write bypass is handled by the caller.
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/input_stream_buffer.sv
// Holds host-written operand words and streams instructed bursts to the array.
module input_stream_buffer
  import sa_buf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ext_data_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic              ext_wr_en_i,
  input  logic              stream_start_i,
  input  logic [ADDR_W-1:0] stream_base_i,
  input  logic [LEN_W-1:0]  stream_len_i,
  output logic [DATA_W-1:0] arr_data_o,
  output logic              arr_valid_o,
  input  logic              arr_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              start_err_o
);

  stream_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] arr_data_q, arr_data_d;
  logic              arr_valid_q, arr_valid_d;
  logic              done_q, done_d;
  logic              start_err_q, start_err_d;

  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] fetch_data;
  logic [LEN_W-1:0]  len_clamped;
  logic              handshake;

  input_buffer_mem u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (ext_wr_en_i),
    .wr_addr_i (ext_addr_i),
    .wr_data_i (ext_data_i),
    .rd_addr_i (fetch_addr),
    .rd_data_o (rd_data)
  );

  // Fetch address and same-cycle write bypass, so a word written as it is fetched is presented.
  always_comb begin
    fetch_addr = (state_q == IDLE) ? stream_base_i : ptr_q + ADDR_W'(1);
    fetch_data = (ext_wr_en_i && (ext_addr_i == fetch_addr)) ? ext_data_i : rd_data;
    len_clamped = (stream_len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : stream_len_i;
    handshake  = arr_valid_q && arr_ready_i;
  end

  // Next-state logic for the burst FSM, counters and output registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    arr_data_d  = arr_data_q;
    arr_valid_d = arr_valid_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (stream_start_i && (stream_len_i != '0)) begin
          ptr_d       = stream_base_i;
          rem_d       = len_clamped;
          arr_data_d  = fetch_data;
          arr_valid_d = 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (stream_start_i) begin
          start_err_d = 1'b1;
        end
        if (handshake) begin
          if (rem_q == LEN_W'(1)) begin
            arr_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            ptr_d      = ptr_q + ADDR_W'(1);
            rem_d      = rem_q - LEN_W'(1);
            arr_data_d = fetch_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst without a done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      arr_data_q  <= '0;
      arr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      arr_data_q  <= arr_data_d;
      arr_valid_q <= arr_valid_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
    end
  end

  // Outputs come straight from registers: no combinational path from arr_ready_i.
  always_comb begin
    arr_data_o  = arr_data_q;
    arr_valid_o = arr_valid_q;
    busy_o      = (state_q == STREAM);
    done_o      = done_q;
    start_err_o = start_err_q;
  end

endmodule

// File: tb/tb_input_stream_buffer.sv
// Self-checking bench for input_stream_buffer: burst table, hand-written corner
// sequences and a randomized phase, all scored against a queue-based model.
module tb_input_stream_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] ext_data;
  logic [3:0]  ext_addr;
  logic        ext_wr_en;
  logic        stream_start;
  logic [3:0]  stream_base;
  logic [4:0]  stream_len;
  logic [31:0] arr_data;
  logic        arr_valid;
  logic        arr_ready;
  logic        busy;
  logic        done;
  logic        start_err;

  input_stream_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ext_data_i     (ext_data),
    .ext_addr_i     (ext_addr),
    .ext_wr_en_i    (ext_wr_en),
    .stream_start_i (stream_start),
    .stream_base_i  (stream_base),
    .stream_len_i   (stream_len),
    .arr_data_o     (arr_data),
    .arr_valid_o    (arr_valid),
    .arr_ready_i    (arr_ready),
    .busy_o         (busy),
    .done_o         (done),
    .start_err_o    (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: memory image, queue of addresses still to deliver, presented word.
  logic [31:0] m_mem [16];
  int          m_q[$];
  logic [31:0] m_cur;
  logic        m_valid;
  logic        m_done;
  logic        m_err;

  // Observation log
  logic [31:0] rx[$];
  int          done_cnt;
  int          err_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_q.delete();
    m_cur   = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: snapshot inputs, advance the model at the edge, compare #1 later.
  task automatic tick();
    logic        s_rst, s_wr, s_start, s_ready, s_valid;
    logic [3:0]  s_addr, s_base;
    logic [4:0]  s_len;
    logic [31:0] s_wdata, s_data;
    logic [31:0] mv [16];
    int          n;
    s_rst = rst; s_wr = ext_wr_en; s_addr = ext_addr; s_wdata = ext_data;
    s_start = stream_start; s_base = stream_base; s_len = stream_len;
    s_ready = arr_ready; s_valid = arr_valid; s_data = arr_data;
    @(posedge clk);
    if (s_rst) begin
      model_reset();
    end else begin
      if (s_valid && s_ready) rx.push_back(s_data);
      mv = m_mem;
      // A same-cycle write is visible to the fetch, so fetch from the post-write image.
      if (s_wr) mv[s_addr] = s_wdata;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_valid) begin
        if (s_start) m_err = 1'b1;
        if (s_ready) begin
          if (m_q.size() == 0) begin
            m_valid = 1'b0;
            m_done  = 1'b1;
          end else begin
            m_cur = mv[m_q.pop_front()];
          end
        end
      end else if (s_start && s_len != 0) begin
        n = (s_len > 16) ? 16 : int'(s_len);
        m_q.delete();
        for (int i = 1; i < n; i++) m_q.push_back((int'(s_base) + i) % 16);
        m_cur   = mv[s_base];
        m_valid = 1'b1;
      end
      m_mem = mv;
    end
    #1;
    chk("arr_valid", {31'd0, arr_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_valid});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("start_err", {31'd0, start_err}, {31'd0, m_err});
    chk("arr_data", arr_data, m_cur);
    if (done) done_cnt++;
    if (start_err) err_cnt++;
  endtask

  task automatic wait_done(input int bound);
    for (int c = 0; c < bound && done_cnt == 0; c++) tick();
  endtask

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  len;
    int          exp_cnt;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } burst_vec_t;

  burst_vec_t vecs[6];

  initial begin
    vecs[0] = '{base: 4'd0,  len: 5'd4,  exp_cnt: 4,  exp_first: 32'hA000_0000, exp_last: 32'hA000_0003};
    vecs[1] = '{base: 4'd14, len: 5'd4,  exp_cnt: 4,  exp_first: 32'hA000_000E, exp_last: 32'hA000_0001};
    vecs[2] = '{base: 4'd3,  len: 5'd20, exp_cnt: 16, exp_first: 32'hA000_0003, exp_last: 32'hA000_0002};
    vecs[3] = '{base: 4'd7,  len: 5'd1,  exp_cnt: 1,  exp_first: 32'hA000_0007, exp_last: 32'hA000_0007};
    vecs[4] = '{base: 4'd9,  len: 5'd0,  exp_cnt: 0,  exp_first: 32'h0,         exp_last: 32'h0};
    vecs[5] = '{base: 4'd15, len: 5'd16, exp_cnt: 16, exp_first: 32'hA000_000F, exp_last: 32'hA000_000E};

    rst = 1'b1; ext_data = '0; ext_addr = '0; ext_wr_en = 1'b0;
    stream_start = 1'b0; stream_base = '0; stream_len = '0; arr_ready = 1'b1;
    done_cnt = 0; err_cnt = 0;
    model_reset();
    #1;
    chk("reset arr_valid", {31'd0, arr_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset arr_data", arr_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Fill memory with a recognisable pattern.
    for (int i = 0; i < 16; i++) begin
      ext_wr_en = 1'b1; ext_addr = 4'(i); ext_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    ext_wr_en = 1'b0;

    // Burst table, ready held high; each start lands in the done cycle of the previous one.
    for (int v = 0; v < 6; v++) begin
      rx.delete();
      done_cnt = 0;
      stream_start = 1'b1; stream_base = vecs[v].base; stream_len = vecs[v].len;
      tick();
      stream_start = 1'b0;
      wait_done(25);
      chk($sformatf("vec%0d words", v), 32'(rx.size()), 32'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d done pulses", v), 32'(done_cnt), (vecs[v].exp_cnt > 0) ? 32'd1 : 32'd0);
      if (vecs[v].exp_cnt > 0 && rx.size() > 0) begin
        chk($sformatf("vec%0d first", v), rx[0], vecs[v].exp_first);
        chk($sformatf("vec%0d last", v), rx[rx.size()-1], vecs[v].exp_last);
      end
    end
    tick();

    // Backpressure: random ready during a len 8 burst.
    rx.delete(); done_cnt = 0;
    stream_start = 1'b1; stream_base = 4'd10; stream_len = 5'd8;
    tick();
    stream_start = 1'b0;
    for (int c = 0; c < 200 && done_cnt == 0; c++) begin
      arr_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    arr_ready = 1'b1;
    chk("bp handshakes", 32'(rx.size()), 32'd8);
    for (int i = 0; i < rx.size(); i++)
      chk($sformatf("bp word%0d", i), rx[i], 32'hA000_0000 + 32'((10 + i) % 16));
    tick();

    // Start while busy: flagged once, burst unchanged.
    rx.delete(); done_cnt = 0; err_cnt = 0;
    stream_start = 1'b1; stream_base = 4'd0; stream_len = 5'd4;
    tick();
    stream_base = 4'd9; stream_len = 5'd2;
    tick();
    stream_start = 1'b0;
    chk("start_err pulse", {31'd0, start_err}, 32'd1);
    wait_done(20);
    chk("err count", 32'(err_cnt), 32'd1);
    chk("err burst words", 32'(rx.size()), 32'd4);
    if (rx.size() == 4) chk("err burst last", rx[3], 32'hA000_0003);
    tick();

    // Write bypass on fetch, then a write under backpressure must not disturb arr_data.
    done_cnt = 0;
    stream_start = 1'b1; stream_base = 4'd4; stream_len = 5'd3;
    tick();
    stream_start = 1'b0;
    ext_wr_en = 1'b1; ext_addr = 4'd5; ext_data = 32'hDEAD_BEEF;
    tick();
    chk("bypass word", arr_data, 32'hDEAD_BEEF);
    arr_ready = 1'b0; ext_data = 32'h1234_5678;
    tick();
    ext_wr_en = 1'b0;
    chk("held word", arr_data, 32'hDEAD_BEEF);
    tick();
    chk("held word 2", arr_data, 32'hDEAD_BEEF);
    arr_ready = 1'b1;
    wait_done(10);
    tick();

    // Asynchronous reset mid-burst.
    done_cnt = 0;
    stream_start = 1'b1; stream_base = 4'd0; stream_len = 5'd8;
    tick();
    stream_start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst arr_valid", {31'd0, arr_valid}, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst arr_data", arr_data, 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("no done after rst", 32'(done_cnt), 32'd0);
    rx.delete();
    stream_start = 1'b1; stream_base = 4'd2; stream_len = 5'd4;
    tick();
    stream_start = 1'b0;
    wait_done(10);
    chk("post-rst words", 32'(rx.size()), 32'd4);
    for (int i = 0; i < rx.size(); i++) chk($sformatf("post-rst word%0d", i), rx[i], 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      ext_wr_en    = $urandom_range(0, 1) == 1;
      ext_addr     = 4'($urandom_range(0, 15));
      ext_data     = $urandom;
      stream_start = $urandom_range(0, 9) == 0;
      stream_base  = 4'($urandom_range(0, 15));
      stream_len   = 5'($urandom_range(0, 20));
      arr_ready    = $urandom_range(0, 3) != 0;
      tick();
    end
    ext_wr_en = 1'b0; stream_start = 1'b0; arr_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
